// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR register-file port.
// Sequences one Zicsr instruction at a time through read, modify and optional write,
// then returns the old CSR value (or an illegal-access flag) to writeback.
module csr_access_unit (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  funct3_i,
    input  logic [11:0] csr_addr_i,
    input  logic [4:0]  rs1_idx_i,
    input  logic [31:0] rs1_val_i,
    input  logic [4:0]  rd_i,
    output logic [11:0] csr_sel_o,
    output logic [31:0] csr_din_o,
    output logic        csr_we_o,
    input  logic [31:0] csr_dout_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [4:0]  resp_rd_o,
    output logic [31:0] resp_data_o,
    output logic        resp_illegal_o
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;            // funct3[1:0]: 01 write, 10 set, 11 clear
    logic [11:0] addr_q, addr_d;
    logic [4:0]  rs1_idx_q, rs1_idx_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] operand_q, operand_d;
    logic [31:0] old_q, old_d;
    logic        req_ready_q, req_ready_d;
    logic [11:0] sel_q, sel_d;
    logic [31:0] din_q, din_d;
    logic        we_q, we_d;
    logic        resp_valid_q, resp_valid_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_illegal_q, resp_illegal_d;

    logic        write_intent;
    logic        read_only;
    logic [31:0] new_val;

    // Decode of the latched instruction; new value is formed from the live read data in READ
    // so that din can be registered for WRITE (it equals the value captured into old_q).
    always_comb begin
        write_intent = (op_q == 2'b01) || (rs1_idx_q != 5'd0);
        read_only    = (addr_q[11:10] == 2'b11);
        unique case (op_q)
            2'b10:   new_val = csr_dout_i | operand_q;
            2'b11:   new_val = csr_dout_i & ~operand_q;
            default: new_val = operand_q;
        endcase
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        rs1_idx_d      = rs1_idx_q;
        rd_d           = rd_q;
        operand_d      = operand_q;
        old_d          = old_q;
        req_ready_d    = req_ready_q;
        sel_d          = 12'd0;
        din_d          = 32'd0;
        we_d           = 1'b0;
        resp_valid_d   = resp_valid_q;
        resp_rd_d      = resp_rd_q;
        resp_data_d    = resp_data_q;
        resp_illegal_d = resp_illegal_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    op_d        = funct3_i[1:0];
                    addr_d      = csr_addr_i;
                    rs1_idx_d   = rs1_idx_i;
                    rd_d        = rd_i;
                    operand_d   = funct3_i[2] ? {27'd0, rs1_idx_i} : rs1_val_i;
                    req_ready_d = 1'b0;
                    if (funct3_i[1:0] == 2'b00) begin
                        // Reserved funct3: respond at once, never touch the CSR port
                        state_d        = StResp;
                        resp_valid_d   = 1'b1;
                        resp_rd_d      = rd_i;
                        resp_data_d    = 32'd0;
                        resp_illegal_d = 1'b1;
                    end else begin
                        state_d = StRead;
                        sel_d   = csr_addr_i;
                    end
                end
            end
            StRead: begin
                old_d   = csr_dout_i;
                state_d = StWrite;
                sel_d   = addr_q;
                din_d   = new_val;
                we_d    = write_intent && !read_only;
            end
            StWrite: begin
                state_d        = StResp;
                resp_valid_d   = 1'b1;
                resp_rd_d      = rd_q;
                resp_illegal_d = write_intent && read_only;
                resp_data_d    = (write_intent && read_only) ? 32'd0 : old_q;
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d        = StIdle;
                    req_ready_d    = 1'b1;
                    resp_valid_d   = 1'b0;
                    resp_rd_d      = 5'd0;
                    resp_data_d    = 32'd0;
                    resp_illegal_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access not yet in WRITE.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            op_q           <= 2'd0;
            addr_q         <= 12'd0;
            rs1_idx_q      <= 5'd0;
            rd_q           <= 5'd0;
            operand_q      <= 32'd0;
            old_q          <= 32'd0;
            req_ready_q    <= 1'b1;
            sel_q          <= 12'd0;
            din_q          <= 32'd0;
            we_q           <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rd_q      <= 5'd0;
            resp_data_q    <= 32'd0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            rs1_idx_q      <= rs1_idx_d;
            rd_q           <= rd_d;
            operand_q      <= operand_d;
            old_q          <= old_d;
            req_ready_q    <= req_ready_d;
            sel_q          <= sel_d;
            din_q          <= din_d;
            we_q           <= we_d;
            resp_valid_q   <= resp_valid_d;
            resp_rd_q      <= resp_rd_d;
            resp_data_q    <= resp_data_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

    assign req_ready_o    = req_ready_q;
    assign csr_sel_o      = sel_q;
    assign csr_din_o      = din_q;
    assign csr_we_o       = we_q;
    assign resp_valid_o   = resp_valid_q;
    assign resp_rd_o      = resp_rd_q;
    assign resp_data_o    = resp_data_q;
    assign resp_illegal_o = resp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small CSR model: 0xC00 is a free-running cycle
// counter, 0x340 is a writable register; everything else reads as zero.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [4:0]  rs1_idx = 5'd0;
    logic [31:0] rs1_val = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic [11:0] csr_sel;
    logic [31:0] csr_din;
    logic        csr_we;
    logic [31:0] csr_dout;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] cyc_cnt;
    logic [31:0] mscratch;
    logic        preset_en = 1'b0;
    logic [31:0] preset_val = 32'd0;
    int          we_total = 0;

    // Observations gathered by the issue task
    int          lat;
    int          we_at;
    logic [31:0] we_din;
    logic [31:0] cnt_snap;

    csr_access_unit dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .funct3_i       (funct3),
        .csr_addr_i     (csr_addr),
        .rs1_idx_i      (rs1_idx),
        .rs1_val_i      (rs1_val),
        .rd_i           (rd),
        .csr_sel_o      (csr_sel),
        .csr_din_o      (csr_din),
        .csr_we_o       (csr_we),
        .csr_dout_i     (csr_dout),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_rd_o      (resp_rd),
        .resp_data_o    (resp_data),
        .resp_illegal_o (resp_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc_cnt <= 32'd0;
        else       cyc_cnt <= cyc_cnt + 32'd1;
    end

    always @(posedge clk) begin
        if (preset_en) mscratch <= preset_val;
        else if (csr_we && csr_sel == 12'h340) mscratch <= csr_din;
        if (csr_we) we_total <= we_total + 1;
    end

    assign csr_dout = (csr_sel == 12'hC00) ? cyc_cnt :
                      (csr_sel == 12'h340) ? mscratch : 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preset(input logic [31:0] v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    // Drive one request in IDLE, then follow it until resp_valid (bounded at 20 cycles).
    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] ri,
                         input logic [31:0] rv, input logic [4:0] rdi);
        @(negedge clk);
        req_valid = 1'b1;
        funct3    = f3;
        csr_addr  = a;
        rs1_idx   = ri;
        rs1_val   = rv;
        rd        = rdi;
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 1;
        we_at     = 0;
        we_din    = 32'd0;
        cnt_snap  = cyc_cnt;
        while (lat < 20) begin
            if (csr_we) begin
                we_at  = lat;
                we_din = csr_din;
            end
            if (resp_valid) break;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          we0;
        logic [31:0] held_data;
        logic [4:0]  held_rd;

        #12;
        reset = 1'b0;
        @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset csr_sel", {20'd0, csr_sel}, 32'd0);
        check("reset csr_we", {31'd0, csr_we}, 32'd0);
        check("reset resp_data", resp_data, 32'd0);

        // CSRRS read of cycle counter, no write intent
        repeat (3) @(negedge clk);
        we0 = we_total;
        issue(3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 5'd5);
        check("rs cycle latency", lat, 3);
        check("rs cycle data", resp_data, cnt_snap);
        check("rs cycle rd", {27'd0, resp_rd}, 32'd5);
        check("rs cycle illegal", {31'd0, resp_illegal}, 32'd0);
        check("rs cycle we count", we_total - we0, 0);

        // CSRRW to writable CSR
        preset(32'h0000_00FF);
        we0 = we_total;
        issue(3'b001, 12'h340, 5'd7, 32'hDEAD_BEEF, 5'd1);
        check("rw latency", lat, 3);
        check("rw we cycle", we_at, 2);
        check("rw din", we_din, 32'hDEAD_BEEF);
        check("rw data", resp_data, 32'h0000_00FF);
        check("rw we count", we_total - we0, 1);
        check("rw csr value", mscratch, 32'hDEAD_BEEF);

        // CSRRCI with zimm
        preset(32'hFFFF_FFFF);
        issue(3'b111, 12'h340, 5'h15, 32'h0, 5'd2);
        check("rci din", we_din, 32'hFFFF_FFEA);
        check("rci data", resp_data, 32'hFFFF_FFFF);
        check("rci csr value", mscratch, 32'hFFFF_FFEA);

        // Write to read-only cycleh
        we0 = we_total;
        issue(3'b001, 12'hC80, 5'd4, 32'h1234_5678, 5'd3);
        check("ro latency", lat, 3);
        check("ro illegal", {31'd0, resp_illegal}, 32'd1);
        check("ro data", resp_data, 32'd0);
        check("ro we count", we_total - we0, 0);

        // Reserved funct3
        issue(3'b100, 12'h340, 5'd4, 32'h1234_5678, 5'd6);
        check("f3 100 latency", lat, 1);
        check("f3 100 illegal", {31'd0, resp_illegal}, 32'd1);
        check("f3 100 data", resp_data, 32'd0);
        check("f3 100 we count", we_total - we0, 0);

        // Backpressure on a CSRRS
        preset(32'h0000_0010);
        resp_ready = 1'b0;
        we0 = we_total;
        issue(3'b010, 12'h340, 5'd3, 32'h0000_0001, 5'd9);
        check("bp latency", lat, 3);
        check("bp data", resp_data, 32'h0000_0010);
        check("bp din", we_din, 32'h0000_0011);
        held_data = resp_data;
        held_rd   = resp_rd;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp hold valid", {31'd0, resp_valid}, 32'd1);
            check("bp hold data", resp_data, held_data);
            check("bp hold rd", {27'd0, resp_rd}, {27'd0, held_rd});
            check("bp hold we", {31'd0, csr_we}, 32'd0);
            check("bp hold req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        check("bp req_ready in resp", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("bp req_ready after", {31'd0, req_ready}, 32'd1);
        check("bp we count", we_total - we0, 1);
        check("bp csr value", mscratch, 32'h0000_0011);

        // Reset mid-READ of a CSRRW
        preset(32'h0000_0042);
        we0 = we_total;
        @(negedge clk);
        req_valid = 1'b1;
        funct3    = 3'b001;
        csr_addr  = 12'h340;
        rs1_idx   = 5'd8;
        rs1_val   = 32'h1234_5678;
        rd        = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid read sel", {20'd0, csr_sel}, 32'h340);
        reset = 1'b1;
        #1;
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst sel", {20'd0, csr_sel}, 32'd0);
        check("rst we", {31'd0, csr_we}, 32'd0);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst we count", we_total - we0, 0);
        check("rst csr value", mscratch, 32'h0000_0042);
        issue(3'b001, 12'h340, 5'd8, 32'hA5A5_A5A5, 5'd4);
        check("post rst latency", lat, 3);
        check("post rst data", resp_data, 32'h0000_0042);
        check("post rst din", we_din, 32'hA5A5_A5A5);
        check("post rst rd", {27'd0, resp_rd}, 32'd4);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
